// File: rtl/alu_execute_stage.sv
// Execute stage: B-operand shifter and ALU behind a two-deep operand/result pipeline,
// feeding the register-file write stage, plus the Z/N/V status register for branches.
module alu_execute_stage #(
    parameter int WIDTH   = 16,
    parameter int REGADDR = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_opa,
    input  logic [WIDTH-1:0]   in_opb,
    input  logic [WIDTH-1:0]   in_imm,
    input  logic               in_asel,
    input  logic               in_bsel,
    input  logic [1:0]         in_shift,
    input  logic [1:0]         in_op,
    input  logic [REGADDR-1:0] in_dest,
    input  logic               in_wr,
    input  logic               in_loads,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_c,
    output logic [REGADDR-1:0] out_writenum,
    output logic               out_write,
    output logic               status_z,
    output logic               status_n,
    output logic               status_v
);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0]   a;
        logic [WIDTH-1:0]   b;
        logic [1:0]         op;
        logic [REGADDR-1:0] dest;
        logic               wr;
        logic               loads;
    } s1_t;

    s1_t                r_s1;
    logic               r_s1_valid;
    logic               r_s2_valid;
    logic [WIDTH-1:0]   r_s2_c;
    logic [REGADDR-1:0] r_s2_dest;
    logic               r_s2_wr;
    logic               r_z, r_n, r_v;

    logic               w_s2_free, w_s1_adv, w_accept;
    logic [WIDTH-1:0]   w_b_shift, w_a_sel, w_b_sel;
    logic [WIDTH-1:0]   w_c;
    logic               w_v;

    assign w_s2_free = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_free;
    assign in_ready  = !r_s1_valid || w_s2_free;
    assign w_accept  = in_valid && in_ready;

    // Shift happens ahead of the immediate mux, so immediates are never shifted.
    always_comb begin
        w_b_shift = in_opb;
        case (in_shift)
            2'b01:   w_b_shift = {in_opb[MSB-1:0], 1'b0};
            2'b10:   w_b_shift = {1'b0, in_opb[MSB:1]};
            2'b11:   w_b_shift = {in_opb[MSB], in_opb[MSB:1]};
            default: w_b_shift = in_opb;
        endcase
    end

    assign w_a_sel = in_asel ? '0 : in_opa;
    assign w_b_sel = in_bsel ? in_imm : w_b_shift;

    always_comb begin
        w_c = '0;
        w_v = 1'b0;
        case (r_s1.op)
            2'b00: begin
                w_c = r_s1.a + r_s1.b;
                w_v = (r_s1.a[MSB] == r_s1.b[MSB]) && (w_c[MSB] != r_s1.a[MSB]);
            end
            2'b01: begin
                w_c = r_s1.a - r_s1.b;
                w_v = (r_s1.a[MSB] != r_s1.b[MSB]) && (w_c[MSB] != r_s1.a[MSB]);
            end
            2'b10:   w_c = r_s1.a & r_s1.b;
            default: w_c = ~r_s1.b;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_s1.a     <= w_a_sel;
                r_s1.b     <= w_b_sel;
                r_s1.op    <= in_op;
                r_s1.dest  <= in_dest;
                r_s1.wr    <= in_wr;
                r_s1.loads <= in_loads;
                r_s1_valid <= 1'b1;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // Flags load on the same edge the result enters stage 2, so CMP (wr=0) still sets them.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid <= 1'b0;
            r_s2_c     <= '0;
            r_s2_dest  <= '0;
            r_s2_wr    <= 1'b0;
            r_z        <= 1'b0;
            r_n        <= 1'b0;
            r_v        <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_valid <= 1'b1;
                r_s2_c     <= w_c;
                r_s2_dest  <= r_s1.dest;
                r_s2_wr    <= r_s1.wr;
                if (r_s1.loads) begin
                    r_z <= (w_c == '0);
                    r_n <= w_c[MSB];
                    r_v <= w_v;
                end
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_s2_valid;
    assign out_c        = r_s2_c;
    assign out_writenum = r_s2_dest;
    assign out_write    = r_s2_valid && r_s2_wr;
    assign status_z     = r_z;
    assign status_n     = r_n;
    assign status_v     = r_v;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Scoreboard bench for alu_execute_stage: an integer-arithmetic reference model fills the
// queue at accept time, and an independent monitor pops and compares on every output handshake.
module tb_alu_execute_stage;
    localparam int W = 16;
    localparam int RA = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_opa = '0, in_opb = '0, in_imm = '0;
    logic          in_asel = 1'b0, in_bsel = 1'b0;
    logic [1:0]    in_shift = '0, in_op = '0;
    logic [RA-1:0] in_dest = '0;
    logic          in_wr = 1'b0, in_loads = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_c;
    logic [RA-1:0] out_writenum;
    logic          out_write;
    logic          status_z, status_n, status_v;

    alu_execute_stage #(.WIDTH(W), .REGADDR(RA)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opa(in_opa), .in_opb(in_opb), .in_imm(in_imm),
        .in_asel(in_asel), .in_bsel(in_bsel), .in_shift(in_shift), .in_op(in_op),
        .in_dest(in_dest), .in_wr(in_wr), .in_loads(in_loads),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_c(out_c), .out_writenum(out_writenum), .out_write(out_write),
        .status_z(status_z), .status_n(status_n), .status_v(status_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned c;
        int unsigned dest;
        bit          wr;
        bit          z, n, v;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   mz = 0, mn = 0, mv = 0;   // model status register

    task automatic chk(input string name, input int unsigned act, input int unsigned req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic int to_signed(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference model: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int unsigned a, input int unsigned b, input int unsigned imm,
                                   input bit asel, input bit bsel, input int unsigned shift,
                                   input int unsigned op, input int unsigned dest, input bit wr);
        exp_t e;
        int unsigned av, bv;
        int r;
        bv = b;
        if (shift == 1) bv = (b * 2) % 65536;
        if (shift == 2) bv = b / 2;
        if (shift == 3) bv = b / 2 + ((b >= 32768) ? 32768 : 0);
        if (bsel) bv = imm;
        av = asel ? 0 : a;
        e.v = 0;
        case (op)
            0: begin
                e.c = (av + bv) % 65536;
                r = to_signed(av) + to_signed(bv);
                e.v = (r > 32767) || (r < -32768);
            end
            1: begin
                e.c = (av + 65536 - bv) % 65536;
                r = to_signed(av) - to_signed(bv);
                e.v = (r > 32767) || (r < -32768);
            end
            2: e.c = av & bv;
            default: e.c = 65535 - bv;
        endcase
        e.z = (e.c == 0);
        e.n = (e.c >= 32768);
        e.dest = dest;
        e.wr = wr;
        return e;
    endfunction

    // Present one op, wait (bounded) for acceptance, push its expectation.
    task automatic issue(input int unsigned a, input int unsigned b, input int unsigned imm,
                         input bit asel, input bit bsel, input int unsigned shift,
                         input int unsigned op, input int unsigned dest, input bit wr, input bit loads);
        exp_t e;
        int guard;
        in_opa = W'(a); in_opb = W'(b); in_imm = W'(imm);
        in_asel = asel; in_bsel = bsel; in_shift = 2'(shift); in_op = 2'(op);
        in_dest = RA'(dest); in_wr = wr; in_loads = loads;
        in_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            guard++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready stuck at 0, expected 1 within 50 cycles");
        end else begin
            e = model(a, b, imm, asel, bsel, shift, op, dest, wr);
            if (loads) begin mz = e.z; mn = e.n; mv = e.v; end
            e.z = mz; e.n = mn; e.v = mv;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        chk("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // Monitor: compares at every handshake and checks outputs hold under backpressure.
    bit            held = 0;
    logic [W-1:0]  h_c;
    logic [RA-1:0] h_n;
    logic          h_w;
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            held = 0;
        end else begin
            if (held) begin
                chk("hold_c", out_c, h_c);
                chk("hold_writenum", out_writenum, h_n);
                chk("hold_write", out_write, h_w);
            end
            held = 0;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_output: got c=0x%0h, expected no output", out_c);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_c", out_c, e.c);
                    chk("out_writenum", out_writenum, e.dest);
                    chk("out_write", out_write, e.wr);
                    chk("status_z", status_z, e.z);
                    chk("status_n", status_n, e.n);
                    chk("status_v", status_v, e.v);
                end
            end else if (out_valid) begin
                held = 1; h_c = out_c; h_n = out_writenum; h_w = out_write;
            end
        end
    end

    // Single op into an empty pipe: out_valid must rise on exactly the second edge.
    task automatic latency_check(input int unsigned c_req);
        @(negedge clk);
        chk("latency_not_early", out_valid, 0);
        @(negedge clk);
        chk("latency_valid", out_valid, 1);
        chk("latency_c", out_c, c_req);
    endtask

    initial begin
        int acc;
        #12;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_c", out_c, 0);
        chk("reset_out_write", out_write, 0);
        chk("reset_flags", {status_z, status_n, status_v}, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", in_ready, 1);

        // ADD R3 and its latency
        issue(16'h0005, 16'h0003, 0, 0, 0, 0, 0, 3, 1, 1);
        latency_check(16'h0008);
        drain();
        // CMP, shifter/bsel, status hold
        issue(16'h8000, 16'h0001, 0, 0, 0, 0, 1, 2, 0, 1);
        issue(0, 16'h8001, 0, 1, 0, 3, 3, 1, 1, 0);
        issue(16'h00FF, 0, 16'hFFF0, 0, 1, 0, 2, 4, 1, 0);
        issue(16'h0001, 16'hFFFF, 0, 0, 0, 0, 0, 5, 1, 1);
        issue(16'h8000, 16'hC000, 0, 0, 0, 0, 2, 6, 1, 0);
        drain();
        chk("flags_held_z", status_z, 1);
        chk("flags_held_n", status_n, 0);

        // Backpressure: with out_ready low only two ops fit in the pipe.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            in_opa = W'(i * 7 + 1); in_opb = W'(i * 3); in_asel = 0; in_bsel = 0;
            in_shift = 0; in_op = 0; in_dest = RA'(i); in_wr = 1; in_loads = 1;
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e = model(i * 7 + 1, i * 3, 0, 0, 0, 0, 0, i, 1);
                mz = e.z; mn = e.n; mv = e.v;
                exp_q.push_back(e);
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready_low", in_ready, 0);
        drain();

        // Randomized traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 300; i++)
                    issue($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535),
                          1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 7),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                for (int i = 0; i < 500; i++) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Async reset with both stages full
        out_ready = 1'b0;
        issue(16'h1111, 16'h2222, 0, 0, 0, 0, 0, 1, 1, 1);
        issue(16'h0000, 16'h0000, 0, 0, 0, 0, 1, 2, 1, 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("areset_out_valid", out_valid, 0);
        chk("areset_out_write", out_write, 0);
        chk("areset_flags", {status_z, status_n, status_v}, 0);
        exp_q.delete();
        mz = 0; mn = 0; mv = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        issue(16'h0010, 16'h0003, 0, 0, 0, 1, 1, 7, 1, 1);
        latency_check(16'h000A);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end
endmodule
